// File: rtl/decode_pack.sv
// decode_pack: packs 16 beats of 4 B-bit lanes (B=4/3/2) LSB-first into 64-bit words.
// Optional lane-overflow flag built only when DECODE_PACK_LANE_CHECK_EN is defined.
module decode_pack (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  level,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy,
    output logic        done,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;
    state_t state, next;
    logic [1:0]  lvl;
    logic [79:0] acc;
    logic [6:0]  cnt;
    logic [4:0]  bc;
    logic [2:0]  wc;
    logic [2:0]  bw;
    logic [4:0]  cw;
    logic [15:0] mask, chunk;
    logic        go, accept, emit, hs;
    always_comb begin
        bw = (lvl == 2'd1) ? 3'd4 : (lvl == 2'd2) ? 3'd3 : 3'd2;
        cw = {bw, 2'b00};
        mask = ~(16'hFFFF << bw);
        chunk = '0;
        for (int i = 0; i < 4; i++)
            chunk = chunk | ((in_data[16*i +: 16] & mask) << (int'(bw) * i));
        go = (state == IDLE) && start && (level != 2'd0);
        // cnt never exceeds 79, so bit 6 alone means cnt>=64
        in_ready = (state == RUN) && !cnt[6] && !bc[4];
        accept = in_valid && in_ready;
        hs = out_valid && out_ready;
        emit = (state == RUN) && cnt[6] && (!out_valid || out_ready);
        busy = state != IDLE;
        next = state;
        case (state)
            IDLE:    next = go ? RUN : IDLE;
            RUN:     next = (emit && (wc + 3'd1 == bw)) ? LAST : RUN;
            LAST:    next = hs ? IDLE : LAST;
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= next;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl       <= '0;
            acc       <= '0;
            cnt       <= '0;
            bc        <= '0;
            wc        <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            done <= (state == LAST) && hs;
            if (go) begin
                lvl <= level;
                acc <= '0;
                cnt <= '0;
                bc  <= '0;
                wc  <= '0;
            end else if (accept) begin
                acc <= acc | (80'(chunk) << cnt);
                cnt <= cnt + 7'(cw);
                bc  <= bc + 5'd1;
            end else if (emit) begin
                acc <= {64'd0, acc[79:64]};
                cnt <= cnt - 7'd64;
                wc  <= wc + 3'd1;
            end
            if (emit) begin
                out_data  <= acc[63:0];
                out_valid <= 1'b1;
            end else if (hs) begin
                out_valid <= 1'b0;
            end
        end
    end
`ifdef DECODE_PACK_LANE_CHECK_EN
    logic over;
    always_comb begin
        over = 1'b0;
        for (int i = 0; i < 4; i++)
            over = over | (|(in_data[16*i +: 16] & ~mask));
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)              err <= 1'b0;
        else if (go)             err <= 1'b0;
        else if (accept && over) err <= 1'b1;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_decode_pack.sv
// tb_decode_pack: random and directed messages checked against a bit-stream model of the packing rule.
module tb_decode_pack;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [1:0]  level = 2'd0;
    logic [63:0] in_data = '0;
    logic        in_ready, out_valid, busy, done, err;
    logic [63:0] out_data;
    logic [15:0] lanes [64];
    int total = 0, bad = 0;

    decode_pack dut (
        .clk(clk), .rst_n(rst_n), .level(level), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Coefficient k's low b bits land at stream bits [k*b +: b].
    function automatic logic [255:0] pack_ref(input int b);
        logic [255:0] s;
        s = '0;
        for (int k = 0; k < 64; k++)
            for (int j = 0; j < b; j++)
                s[k*b + j] = lanes[k][j];
        return s;
    endfunction

    function automatic logic err_ref(input int b);
`ifdef DECODE_PACK_LANE_CHECK_EN
        for (int k = 0; k < 64; k++)
            if ((lanes[k] >> b) != 16'd0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // mode 0: full rate, 1: random valid/ready plus stray starts, 2: 10-cycle stall on first word
    task automatic run_msg(input logic [1:0] lv, input int mode, input int abort_at);
        int b, j, bi, wi, hold;
        bit seen, dexp, pend, fin, ih, oh;
        logic [63:0] prev;
        logic [255:0] exp;
        b = 5 - int'(lv);
        j = 0; bi = 0; wi = 0; hold = 0;
        seen = 0; dexp = 0; pend = 0; fin = 0;
        prev = '0;
        exp = pack_ref(b);
        @(negedge clk);
        level = lv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("busy_start", 64'(busy), 64'd1);
        check("err_clear", 64'(err), 64'd0);
        while (!fin && j < 400) begin
            j++;
            if (mode == 2 && !seen && out_valid) begin
                seen = 1; hold = 10;
            end
            in_valid = (bi < 16) && (mode != 1 || $urandom_range(0, 1) == 1);
            if (bi < 16) in_data = {lanes[4*bi+3], lanes[4*bi+2], lanes[4*bi+1], lanes[4*bi]};
            out_ready = (hold > 0) ? 1'b0 : (mode != 1 || $urandom_range(0, 2) != 0);
            start = (mode == 1) && (wi < b) && ($urandom_range(0, 7) == 0);
            level = 2'($urandom);
            #1;
            check("done", 64'(done), 64'(dexp));
            check("busy", 64'(busy), 64'(!dexp));
            if (pend) check("hold_data", out_data, prev);
            if (hold == 1) check("stall_in_ready", 64'(in_ready), 64'd0);
            if (hold > 0) hold--;
            ih = in_valid && in_ready;
            oh = out_valid && out_ready;
            if (oh) begin
                check($sformatf("word%0d", wi), out_data, exp[64*wi +: 64]);
                if (mode == 0 && wi == b - 1) check("latency", 64'(j), 64'(17 + b));
            end
            fin = dexp;
            pend = out_valid && !out_ready;
            prev = out_data;
            @(posedge clk);
            if (ih) bi++;
            if (oh) wi++;
            dexp = oh && (wi == b);
            if (abort_at > 0 && bi == abort_at) break;
            @(negedge clk);
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        if (abort_at > 0) begin
            @(negedge clk);
            rst_n = 1'b0;
            #1;
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_in_ready", 64'(in_ready), 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_done", 64'(done), 64'd0);
            check("rst_out_data", out_data, 64'd0);
            check("rst_err", 64'(err), 64'd0);
            @(negedge clk);
            rst_n = 1'b1;
        end else begin
            #1;
            check("timeout", 64'(fin), 64'd1);
            check("done_pulse", 64'(done), 64'd0);
            check("beats", 64'(bi), 64'd16);
            check("words", 64'(wi), 64'(b));
            check("err_final", 64'(err), 64'(err_ref(b)));
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_out_data", out_data, 64'd0);
        check("reset_err", 64'(err), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        level = 2'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("level0_ignored", 64'(busy), 64'd0);

        for (int k = 0; k < 64; k++) lanes[k] = 16'h0003;
        run_msg(2'd3, 0, 0);
        for (int k = 0; k < 64; k++) lanes[k] = 16'(k % 4 + 1);
        run_msg(2'd1, 0, 0);
        run_msg(2'd2, 0, 0);
        run_msg(2'd2, 2, 0);
        run_msg(2'd1, 0, 5);
        run_msg(2'd1, 0, 0);
        for (int k = 0; k < 64; k++) lanes[k] = 16'h0003;
        lanes[10] = 16'h0007;
        run_msg(2'd3, 0, 0);
        for (int k = 0; k < 64; k++) lanes[k] = 16'h0003;
        run_msg(2'd3, 0, 0);

        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 64; k++)
                lanes[k] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
            run_msg(2'($urandom_range(1, 3)), (r % 3 == 2) ? 2 : 1, 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
